// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl
//
// Multi-source interrupt controller sitting in front of the control unit's
// single interrupt input. Each source is captured into a pending register
// (edge- or level-triggered per source), masked by a per-source enable, and
// the lowest-index eligible source wins. The winner is presented to the CU
// and further interrupts are held off until the handler executes mret; there
// is no nesting and no preemption of an outstanding request.
//
// Parameters
//   NUM_SRC    number of interrupt sources (2..32)
//   ID_W       width of the source ID
//
// Ports
//   clk        system clock, rising edge
//   RST_N      synchronous active-low reset
//   irq_src    raw request lines, already synchronous to clk
//   irq_en     per-source enable mask
//   irq_edge   per-source trigger type: 1 = rising edge, 0 = level
//   mie        global interrupt enable
//   pend_clr   one-cycle software clear of pending bits
//   intr_ack   one-cycle pulse when the CU enters its interrupt state
//   mret       one-cycle pulse when mret executes
//   intr       interrupt request to the CU (registered, no input-to-output path)
//   intr_id    ID of the selected source, held from selection until next pick
//   in_service high while a handler is running
//   pending    pending register, readable via CSR
// -----------------------------------------------------------------------------
module intr_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               RST_N,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_en,
  input  logic [NUM_SRC-1:0] irq_edge,
  input  logic               mie,
  input  logic [NUM_SRC-1:0] pend_clr,
  input  logic               intr_ack,
  input  logic               mret,
  output logic               intr,
  output logic [ID_W-1:0]    intr_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] irq_src_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [ID_W-1:0]    intr_id_q, intr_id_d;

  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] id_onehot;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] ack_clr;
  logic [ID_W-1:0]    winner;
  logic               ack_take;
  logic               req_live;

  // ---------------------------------------------------------------------------
  // Eligibility and fixed-priority selection (index 0 highest)
  // ---------------------------------------------------------------------------
  assign elig = pending_q & irq_en;

  // Scanning from the top down lets the lowest set index overwrite last.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) winner = ID_W'(i);
    end
  end

  // One-hot decode of the held ID; a loop avoids out-of-range indexing when
  // NUM_SRC is not a power of two.
  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      id_onehot[i] = (intr_id_q == ID_W'(i));
    end
  end

  // The presented request is still valid only while its own source remains
  // pending and enabled.
  assign req_live = |(id_onehot & elig);

  // An ack only counts while a request is actually outstanding.
  assign ack_take = (state_q == ST_REQ) && intr_ack;
  assign ack_clr  = id_onehot & {NUM_SRC{ack_take}};

  // ---------------------------------------------------------------------------
  // Pending update
  // ---------------------------------------------------------------------------
  assign rise = irq_src & ~irq_src_q;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (irq_edge[i]) begin
        // Set has priority over any clear so a coincident new edge survives.
        pending_d[i] = rise[i] | (pending_q[i] & ~(pend_clr[i] | ack_clr[i]));
      end else begin
        // Level sources follow the line; the device must drop it to retire.
        pending_d[i] = irq_src[i] & ~pend_clr[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request/service state machine
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    intr_id_d = intr_id_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mie && (elig != '0)) begin
          intr_id_d = winner;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        // intr_id is frozen here: a later higher-priority arrival waits.
        if (intr_ack) begin
          state_d = ST_SERVICE;
        end else if (!mie || !req_live) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (mret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      irq_src_q <= '0;
      pending_q <= '0;
      intr_id_q <= '0;
    end else begin
      state_q   <= state_d;
      irq_src_q <= irq_src;
      pending_q <= pending_d;
      intr_id_q <= intr_id_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs decode from registered state only
  // ---------------------------------------------------------------------------
  assign intr       = (state_q == ST_REQ);
  assign in_service = (state_q == ST_SERVICE);
  assign intr_id    = intr_id_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intr_ctrl
//
// Directed bench for intr_ctrl (NUM_SRC = 8). Each step drives inputs just
// after a rising edge, advances one clock, pushes the values the outputs must
// hold into a scoreboard queue, and check() pops and compares them.
// -----------------------------------------------------------------------------
module tb_intr_ctrl;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 3;

  logic               clk = 1'b0;
  logic               RST_N;
  logic [NUM_SRC-1:0] irq_src;
  logic [NUM_SRC-1:0] irq_en;
  logic [NUM_SRC-1:0] irq_edge;
  logic               mie;
  logic [NUM_SRC-1:0] pend_clr;
  logic               intr_ack;
  logic               mret;
  logic               intr;
  logic [ID_W-1:0]    intr_id;
  logic               in_service;
  logic [NUM_SRC-1:0] pending;

  intr_ctrl #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
    .clk       (clk),
    .RST_N     (RST_N),
    .irq_src   (irq_src),
    .irq_en    (irq_en),
    .irq_edge  (irq_edge),
    .mie       (mie),
    .pend_clr  (pend_clr),
    .intr_ack  (intr_ack),
    .mret      (mret),
    .intr      (intr),
    .intr_id   (intr_id),
    .in_service(in_service),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  typedef enum {S_INTR, S_ID, S_INSV, S_PEND} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] observe(sig_e s);
    case (s)
      S_INTR:  return 32'(intr);
      S_ID:    return 32'(intr_id);
      S_INSV:  return 32'(in_service);
      default: return 32'(pending);
    endcase
  endfunction

  function automatic void want(string tag, sig_e s, logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.exp = v;
    sb_q.push_back(e);
  endfunction

  // Expected intr / in_service / pending after the step.
  function automatic void want_st(string tag, logic i, logic s, logic [7:0] p);
    want({tag, ".intr"}, S_INTR, 32'(i));
    want({tag, ".in_service"}, S_INSV, 32'(s));
    want({tag, ".pending"}, S_PEND, 32'(p));
  endfunction

  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.sig);
      checks++;
      assert (obs === e.exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Hard time bound in case anything stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N    = 1'b0;
    irq_src  = 8'hFF;
    irq_en   = 8'h00;
    irq_edge = 8'h00;
    mie      = 1'b0;
    pend_clr = 8'h00;
    intr_ack = 1'b0;
    mret     = 1'b0;

    // 1. Reset
    cyc(); cyc();
    want_st("reset", 1'b0, 1'b0, 8'h00);
    want("reset.id", S_ID, 32'd0);
    check();
    RST_N   = 1'b1;
    irq_src = 8'h00;
    cyc();
    want_st("post_reset", 1'b0, 1'b0, 8'h00);
    want("post_reset.id", S_ID, 32'd0);
    check();

    // 2. Single edge source 3
    irq_edge = 8'hFD;   // bit 1 level, all others edge
    irq_en   = 8'hFF;
    mie      = 1'b1;
    irq_src  = 8'h08;
    cyc();               // edge k
    want_st("e3_k", 1'b0, 1'b0, 8'h08);
    check();
    irq_src = 8'h00;
    cyc();               // edge k+1
    want_st("e3_k1", 1'b1, 1'b0, 8'h08);
    want("e3_k1.id", S_ID, 32'd3);
    check();
    intr_ack = 1'b1;
    cyc();
    intr_ack = 1'b0;
    want_st("e3_ack", 1'b0, 1'b1, 8'h00);
    want("e3_ack.id", S_ID, 32'd3);
    check();
    cyc();
    want_st("e3_hold", 1'b0, 1'b1, 8'h00);
    check();
    mret = 1'b1;
    cyc();
    mret = 1'b0;
    want_st("e3_mret", 1'b0, 1'b0, 8'h00);
    check();

    // 3. Priority and no-preempt
    irq_src = 8'h24;
    cyc();
    irq_src = 8'h00;
    cyc();
    want_st("prio_req", 1'b1, 1'b0, 8'h24);
    want("prio_req.id", S_ID, 32'd2);
    check();
    intr_ack = 1'b1;
    cyc();
    intr_ack = 1'b0;
    want_st("prio_ack", 1'b0, 1'b1, 8'h20);
    check();
    mret = 1'b1;
    cyc();
    mret = 1'b0;
    want_st("prio_mret", 1'b0, 1'b0, 8'h20);
    check();
    cyc();
    want_st("prio_rearm", 1'b1, 1'b0, 8'h20);
    want("prio_rearm.id", S_ID, 32'd5);
    check();
    irq_src = 8'h01;
    cyc();
    irq_src = 8'h00;
    cyc();
    want_st("nopreempt", 1'b1, 1'b0, 8'h21);
    want("nopreempt.id", S_ID, 32'd5);
    check();
    intr_ack = 1'b1; cyc(); intr_ack = 1'b0;
    mret = 1'b1;     cyc(); mret = 1'b0;
    cyc();
    want_st("src0_req", 1'b1, 1'b0, 8'h01);
    want("src0_req.id", S_ID, 32'd0);
    check();
    intr_ack = 1'b1; cyc(); intr_ack = 1'b0;
    mret = 1'b1;     cyc(); mret = 1'b0;
    want_st("prio_done", 1'b0, 1'b0, 8'h00);
    check();

    // 4. Masking and withdrawal
    irq_en  = 8'hEF;
    irq_src = 8'h10;
    cyc();
    irq_src = 8'h00;
    cyc(); cyc();
    want_st("masked", 1'b0, 1'b0, 8'h10);
    check();
    pend_clr = 8'h10;
    cyc();
    pend_clr = 8'h00;
    want_st("sw_clr", 1'b0, 1'b0, 8'h00);
    check();
    irq_en  = 8'hFF;
    irq_src = 8'h80;
    cyc();
    irq_src = 8'h00;
    cyc();
    want_st("wd_req", 1'b1, 1'b0, 8'h80);
    want("wd_req.id", S_ID, 32'd7);
    check();
    mie = 1'b0;
    cyc();
    want_st("wd_mie0", 1'b0, 1'b0, 8'h80);
    check();
    mie = 1'b1;
    cyc();
    want_st("wd_mie1", 1'b1, 1'b0, 8'h80);
    want("wd_mie1.id", S_ID, 32'd7);
    check();
    intr_ack = 1'b1; cyc(); intr_ack = 1'b0;
    mret = 1'b1;     cyc(); mret = 1'b0;

    // 5. Level source 1 and clear race
    irq_src = 8'h02;
    cyc();
    cyc();
    want_st("lvl_req", 1'b1, 1'b0, 8'h02);
    want("lvl_req.id", S_ID, 32'd1);
    check();
    intr_ack = 1'b1;
    cyc();
    intr_ack = 1'b0;
    want_st("lvl_ack", 1'b0, 1'b1, 8'h02);
    check();
    mret = 1'b1; cyc(); mret = 1'b0;
    cyc();
    want_st("lvl_rearm", 1'b1, 1'b0, 8'h02);
    want("lvl_rearm.id", S_ID, 32'd1);
    check();
    irq_src = 8'h00;
    cyc();
    cyc();
    want_st("lvl_drop", 1'b0, 1'b0, 8'h00);
    check();
    mie     = 1'b0;
    irq_src = 8'h40;
    cyc();
    irq_src = 8'h00;
    cyc();
    irq_src  = 8'h40;
    pend_clr = 8'h40;
    cyc();
    want_st("race_set_wins", 1'b0, 1'b0, 8'h40);
    check();
    cyc();               // clear held, line high but no new edge
    pend_clr = 8'h00;
    want_st("race_clr", 1'b0, 1'b0, 8'h00);
    check();
    irq_src = 8'h00;
    cyc();

    // 6. Stray inputs and reset mid-operation
    mie      = 1'b1;
    intr_ack = 1'b1;
    cyc();
    intr_ack = 1'b0;
    want_st("stray_ack", 1'b0, 1'b0, 8'h00);
    check();
    irq_src = 8'h08;
    cyc();
    irq_src = 8'h00;
    cyc();
    mret = 1'b1;
    cyc();
    mret = 1'b0;
    want_st("stray_mret", 1'b1, 1'b0, 8'h08);
    want("stray_mret.id", S_ID, 32'd3);
    check();
    intr_ack = 1'b1;
    cyc();
    intr_ack = 1'b0;
    irq_src  = 8'h04;
    cyc();
    want_st("svc_accum", 1'b0, 1'b1, 8'h04);
    check();
    RST_N   = 1'b0;
    irq_src = 8'h00;
    cyc();
    want_st("mid_reset", 1'b0, 1'b0, 8'h00);
    want("mid_reset.id", S_ID, 32'd0);
    check();
    RST_N = 1'b1;
    cyc();
    want_st("after_reset", 1'b0, 1'b0, 8'h00);
    check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
